line_buffer_fetch: RTL and testbench
====================================

Name: line_buffer_fetch

Overview:
- SDRAM read client on the arbiter's line-buffer channel. During scanline Y it fetches the framebuffer row for line Y+1 into a ping-pong pair of on-chip line banks.
- It also serves 16-bit pixels from the displayed bank to the VGA colour path, indexed by DrawX.
- Sits directly upstream of the SDRAM arbiter. Its busy and done flags drive the arbiter's Line_buffer state exits.

Parameters:
- H_PIXELS, 640, visible pixels per line.
- V_LINES, 480, visible lines per frame.
- WORDS_PER_LINE, 80, 128-bit SDRAM words per line (8 x 16-bit pixels each).
- FB_BASE, 22'h000000, word address of framebuffer 0.
- FB_STRIDE, 22'h009600, word offset of framebuffer 1 (used only with the optional feature).

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- DrawX  in  10  current horizontal pixel counter (0..799)
- DrawY  in  10  current vertical line counter (0..524)
- new_frame  in  1  one-cycle pulse at frame start
- lb_sdram_Wait  in  1  arbiter grant; 0 = channel granted
- lb_sdram_ac  in  1  arbiter acknowledge; read data valid in this cycle
- lb_sdram_data  in  128  read data
- lb_sdram_rd  out  1  read request
- lb_sdram_addr  out  22  read word address
- lb_Busy  out  1  line fetch pending or in progress
- lb_done  out  1  last visible line of the frame has been fetched
- pixel_out  out  16  RGB565 pixel for the current DrawX/DrawY
- lb_underrun  out  1  sticky flag: bank swap occurred before its fetch completed

Behaviour:
- Reset (async, active-high): all outputs 0; FSM -> IDLE; word index 0, write bank 0, line target 0. Bank RAM contents are not cleared.
- Trigger: one-cycle pulse when DrawX==799.
  - Target line T = (DrawY==524) ? 0 : DrawY+1.
  - Fetch requested only if T < V_LINES; otherwise no fetch and lb_Busy stays 0.
- Bank swap on the same trigger pulse: read bank <= write bank; write bank toggles.
  - If a fetch is still in progress at the trigger, set lb_underrun (cleared only by reset).
  - The outstanding request completes its handshake, then the fetch restarts at word 0 for the new T.
- FSM states:
  - IDLE: on trigger with valid T, go to PEND; lb_Busy <= 1.
  - PEND: wait for lb_sdram_Wait==0, then REQ.
  - REQ: assert lb_sdram_rd; address = base + T*WORDS_PER_LINE + idx. Hold rd and address stable until lb_sdram_ac==1.
    - If Wait rises before ac, drop rd and return to PEND; address and idx are kept.
  - On ac: write lb_sdram_data into bank[write][idx], then go to GAP. rd is 0 in GAP for exactly one cycle.
  - GAP: if idx==WORDS_PER_LINE-1, go to LDONE; else idx+1 and back to REQ.
  - LDONE: lb_Busy <= 0; if T==V_LINES-1, lb_done <= 1; return to IDLE.
- lb_done: held high until new_frame. On new_frame it clears in the next cycle. If new_frame and LDONE coincide, new_frame wins.
- Address arithmetic: 22-bit unsigned; the product T*WORDS_PER_LINE is computed in 22 bits, with no overflow for legal parameters.
- Throughput: minimum 3 cycles per word (REQ, ac, GAP), assuming ac arrives one cycle after rd.
- Pixel path: pixel_out = bank[read][DrawX[9:3]] bits [DrawX[2:0]*16 +: 16], registered (1-cycle latency from DrawX).
  - Forced to 16'h0000 when DrawX>=H_PIXELS or DrawY>=V_LINES.
- Reset mid-fetch: rd drops immediately (async); no partial word is written.

Optional Feature:
- Macro: LB_FRAME_SWAP_EN.
- With the macro defined:
  - Adds input fb_select (1 bit), sampled on new_frame.
  - base = FB_BASE + (sel ? FB_STRIDE : 0), held constant for the whole frame. This gives double-buffered frames.
- Without the macro: no fb_select port; base is always FB_BASE.

Test Plan:
- Line fetch with ac one cycle after each rd, DrawY=10, DrawX reaching 799:
  - Expect 80 reads at addresses 880..959, each rd held until ac.
  - lb_Busy falls after the 80th ac; no lb_done.
- DrawY=478 trigger:
  - Fetch of line 479 (addresses 38320..38399) ends with lb_done=1.
  - lb_done holds until new_frame, clears one cycle after it.
- Grant revoked: Wait goes 1 mid-REQ before ac, at idx=5.
  - Expect rd drops.
  - After Wait=0, rd re-asserts with the same address; no idx skip.
- Pixel readback: bank word 3 = 128'h0007_0006_..._0000 (pixel k = k), next line displayed.
  - DrawX=24..31 gives pixel_out 0..7, one cycle late.
  - DrawX=700 gives 0.
- Underrun: ac withheld so the fetch is incomplete at the next DrawX==799.
  - lb_underrun=1 and banks swap.
  - Fetch restarts at word 0 of the new T after the pending ac.
- Async reset asserted during REQ: rd, lb_Busy, lb_done, pixel_out all go 0 without a clock edge. With LB_FRAME_SWAP_EN and fb_select=1, line 0 address = 22'h009600.

Source files
------------

// File: rtl/line_buffer_fetch_if.sv
// SDRAM line-buffer channel between line_buffer_fetch (master) and the SDRAM arbiter (slave).
interface line_buffer_fetch_if;
  logic         lb_sdram_Wait;
  logic         lb_sdram_ac;
  logic [127:0] lb_sdram_data;
  logic         lb_sdram_rd;
  logic [21:0]  lb_sdram_addr;
  logic         lb_Busy;
  logic         lb_done;

  modport master (
    input  lb_sdram_Wait, lb_sdram_ac, lb_sdram_data,
    output lb_sdram_rd, lb_sdram_addr, lb_Busy, lb_done
  );

  modport slave (
    output lb_sdram_Wait, lb_sdram_ac, lb_sdram_data,
    input  lb_sdram_rd, lb_sdram_addr, lb_Busy, lb_done
  );
endinterface

// File: rtl/line_buffer_fetch.sv
// Line-buffer fetch: prefetches the next scanline from SDRAM into ping-pong banks and serves pixels by DrawX.
// Optional LB_FRAME_SWAP_EN adds fb_select, sampled on new_frame, choosing framebuffer 0 or 1.
//
// state | meaning
// IDLE  | no fetch pending
// PEND  | fetch pending, waiting for the arbiter grant
// REQ   | read request for word idx on the bus, held until ac
// GAP   | one idle cycle after ac, advance idx
// LDONE | whole line written, drop busy, flag last visible line
module line_buffer_fetch #(
  parameter int          H_PIXELS       = 640,
  parameter int          V_LINES        = 480,
  parameter int          WORDS_PER_LINE = 80,
  parameter logic [21:0] FB_BASE        = 22'h000000,
  parameter logic [21:0] FB_STRIDE      = 22'h009600
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [9:0]          DrawX,
  input  logic [9:0]          DrawY,
  input  logic                new_frame,
`ifdef LB_FRAME_SWAP_EN
  input  logic                fb_select,
`endif
  line_buffer_fetch_if.master lb,
  output logic [15:0]         pixel_out,
  output logic                lb_underrun
);

  localparam int                IDX_W    = $clog2(WORDS_PER_LINE);
  localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(WORDS_PER_LINE - 1);
  localparam logic [9:0]        X_TRIG   = 10'd799;
  localparam logic [9:0]        Y_LAST   = 10'd524;
  localparam logic [9:0]        H_VIS    = 10'(H_PIXELS);
  localparam logic [9:0]        V_VIS    = 10'(V_LINES);
  localparam logic [9:0]        T_LAST   = 10'(V_LINES - 1);

  typedef enum logic [2:0] {S_IDLE, S_PEND, S_REQ, S_GAP, S_LDONE} state_t;

  state_t           state, state_nx;
  logic             trig_eq_q, trig;
  logic [9:0]       t_calc, t_pend, line_t, take_t;
  logic             t_calc_ok, t_pend_ok, take_ok, take;
  logic             abort_q, req_end, in_fetch;
  logic [IDX_W-1:0] idx;
  logic             wr_bank, rd_bank;
  logic             frame_sel;
  logic [21:0]      base;
  logic [127:0]     bank_mem [2][WORDS_PER_LINE];
  logic [127:0]     rd_word;
  logic [IDX_W-1:0] px_word;
  logic             pix_vis;

`ifdef LB_FRAME_SWAP_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset)          frame_sel <= 1'b0;
    else if (new_frame) frame_sel <= fb_select;
  end
`else
  assign frame_sel = 1'b0;
`endif

  assign base      = FB_BASE + (frame_sel ? FB_STRIDE : 22'd0);
  assign trig      = (DrawX == X_TRIG) && !trig_eq_q;
  assign t_calc    = (DrawY == Y_LAST) ? 10'd0 : DrawY + 10'd1;
  assign t_calc_ok = (t_calc < V_VIS);
  assign req_end   = lb.lb_sdram_ac || lb.lb_sdram_Wait;
  assign in_fetch  = (state == S_PEND) || (state == S_REQ) || (state == S_GAP);

  // A trigger during REQ is parked in abort_q until the bus handshake ends.
  always_comb begin
    take    = 1'b0;
    take_t  = t_calc;
    take_ok = t_calc_ok;
    if (state == S_REQ) begin
      if (req_end && (abort_q || trig)) begin
        take = 1'b1;
        if (!trig) begin
          take_t  = t_pend;
          take_ok = t_pend_ok;
        end
      end
    end else begin
      take = trig;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    if (take) begin
      state_nx = take_ok ? S_PEND : S_IDLE;
    end else begin
      case (state)
        S_IDLE:  state_nx = S_IDLE;
        S_PEND:  if (!lb.lb_sdram_Wait) state_nx = S_REQ;
        S_REQ: begin
          if (lb.lb_sdram_ac)        state_nx = S_GAP;
          else if (lb.lb_sdram_Wait) state_nx = S_PEND;
        end
        S_GAP:   state_nx = (idx == IDX_LAST) ? S_LDONE : S_REQ;
        S_LDONE: state_nx = S_IDLE;
        default: state_nx = S_IDLE;
      endcase
    end
  end

  always_comb begin
    lb.lb_sdram_rd   = (state == S_REQ);
    lb.lb_sdram_addr = base + 22'(line_t) * 22'(WORDS_PER_LINE) + 22'(idx);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      trig_eq_q   <= 1'b0;
      t_pend      <= '0;
      t_pend_ok   <= 1'b0;
      abort_q     <= 1'b0;
      idx         <= '0;
      line_t      <= '0;
      wr_bank     <= 1'b0;
      rd_bank     <= 1'b0;
      lb.lb_Busy  <= 1'b0;
      lb.lb_done  <= 1'b0;
      lb_underrun <= 1'b0;
    end else begin
      trig_eq_q <= (DrawX == X_TRIG);
      if (trig) begin
        rd_bank   <= wr_bank;
        wr_bank   <= ~wr_bank;
        t_pend    <= t_calc;
        t_pend_ok <= t_calc_ok;
        if (in_fetch) lb_underrun <= 1'b1;
      end
      abort_q <= (state == S_REQ) && !req_end && (abort_q || trig);
      if (take) begin
        idx    <= '0;
        line_t <= take_t;
      end else if ((state == S_GAP) && (idx != IDX_LAST)) begin
        idx <= idx + IDX_W'(1);
      end
      if (take)                  lb.lb_Busy <= take_ok;
      else if (state == S_LDONE) lb.lb_Busy <= 1'b0;
      if (new_frame)                                  lb.lb_done <= 1'b0;
      else if ((state == S_LDONE) && (line_t == T_LAST)) lb.lb_done <= 1'b1;
    end
  end

  // Data that arrives for an abandoned line is dropped.
  always_ff @(posedge clk) begin
    if ((state == S_REQ) && lb.lb_sdram_ac && !abort_q)
      bank_mem[wr_bank][idx] <= lb.lb_sdram_data;
  end

  assign pix_vis = (DrawX < H_VIS) && (DrawY < V_VIS);
  assign px_word = pix_vis ? DrawX[IDX_W+2:3] : '0;
  assign rd_word = bank_mem[rd_bank][px_word];

  always_ff @(posedge clk or posedge reset) begin
    if (reset)        pixel_out <= 16'h0000;
    else if (pix_vis) pixel_out <= rd_word[{DrawX[2:0], 4'b0000} +: 16];
    else              pixel_out <= 16'h0000;
  end

endmodule

// File: tb/tb_line_buffer_fetch.sv
// Scoreboard bench for line_buffer_fetch: an arbiter model answers reads, monitors pop expected addresses and pixels.
module tb_line_buffer_fetch;
  logic        clk = 1'b0;
  logic        reset;
  logic [9:0]  DrawX, DrawY;
  logic        new_frame;
  logic [15:0] pixel_out;
  logic        lb_underrun;
`ifdef LB_FRAME_SWAP_EN
  logic        fb_select;
`endif

  line_buffer_fetch_if lb();

  line_buffer_fetch dut (
    .clk         (clk),
    .reset       (reset),
    .DrawX       (DrawX),
    .DrawY       (DrawY),
    .new_frame   (new_frame),
`ifdef LB_FRAME_SWAP_EN
    .fb_select   (fb_select),
`endif
    .lb          (lb),
    .pixel_out   (pixel_out),
    .lb_underrun (lb_underrun)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          due;
    logic [15:0] val;
    string       name;
  } pix_t;

  int          errors = 0;
  int          checks = 0;
  int          cyc    = 0;
  bit          ac_en  = 1'b1;
  logic [21:0] addr_q[$];
  pix_t        pix_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Framebuffer pattern: word w of line L, pixel k = {(w^3)^(L^11), k}.
  function automatic logic [127:0] word_data(input logic [21:0] a);
    logic [127:0] d;
    int line = int'(a) / 80;
    int w    = int'(a) % 80;
    for (int k = 0; k < 8; k++)
      d[k*16 +: 16] = {8'(w ^ 3) ^ 8'(line ^ 11), 8'(k)};
    return d;
  endfunction

  // Arbiter model and read monitor: ac one cycle after rd is seen, address checked at each handshake.
  initial begin
    int          rd_cnt = 0;
    logic        prev_rd = 1'b0;
    logic [21:0] prev_addr = '0;
    logic [21:0] exp_a;
    lb.lb_sdram_ac   = 1'b0;
    lb.lb_sdram_data = '0;
    forever begin
      @(negedge clk);
      if (lb.lb_sdram_rd && prev_rd)
        check("rd_addr_stable", 32'(lb.lb_sdram_addr), 32'(prev_addr));
      prev_rd   = lb.lb_sdram_rd;
      prev_addr = lb.lb_sdram_addr;
      if (lb.lb_sdram_ac) begin
        lb.lb_sdram_ac = 1'b0;
        rd_cnt = 0;
      end else begin
        rd_cnt = lb.lb_sdram_rd ? ((rd_cnt < 2) ? rd_cnt + 1 : 2) : 0;
        if (rd_cnt == 2 && ac_en && !lb.lb_sdram_Wait) begin
          if (addr_q.size() == 0) begin
            check("unexpected_read", 32'(lb.lb_sdram_addr), 32'h3FFFFF);
          end else begin
            exp_a = addr_q.pop_front();
            check("read_addr", 32'(lb.lb_sdram_addr), 32'(exp_a));
          end
          lb.lb_sdram_data = word_data(lb.lb_sdram_addr);
          lb.lb_sdram_ac   = 1'b1;
        end
      end
    end
  end

  // Pixel monitor: entries become due one clock after the DrawX they were pushed with.
  initial begin
    pix_t p;
    forever begin
      @(negedge clk);
      while (pix_q.size() > 0 && pix_q[0].due <= cyc) begin
        p = pix_q.pop_front();
        check(p.name, 32'(pixel_out), 32'(p.val));
      end
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic trigger(input logic [9:0] y);
    DrawY = y;
    DrawX = 10'd799;
    tick();
    DrawX = 10'd0;
  endtask

  task automatic push_line(input int t, input int first, input int n);
    for (int i = first; i < first + n; i++) addr_q.push_back(22'(t * 80 + i));
  endtask

  task automatic push_pix(input string name, input logic [9:0] x, input logic [15:0] v);
    pix_t p;
    DrawX  = x;
    p.due  = cyc + 1;
    p.val  = v;
    p.name = name;
    pix_q.push_back(p);
    tick();
  endtask

  task automatic wait_idle(input string name, input int limit);
    int n = 0;
    while (lb.lb_Busy && n < limit) begin
      tick();
      n++;
    end
    checks++;
    if (lb.lb_Busy) begin
      errors++;
      $display("FAIL %s: busy still 1 after %0d cycles, required 0", name, limit);
    end
  endtask

  task automatic wait_req(input string name, input logic [21:0] a, input int limit);
    int n = 0;
    while (!(lb.lb_sdram_rd && lb.lb_sdram_addr == a) && n < limit) begin
      tick();
      n++;
    end
    checks++;
    if (!(lb.lb_sdram_rd && lb.lb_sdram_addr == a)) begin
      errors++;
      $display("FAIL %s: rd=%0b addr=%0h, required rd=1 addr=%0h", name, lb.lb_sdram_rd, lb.lb_sdram_addr, a);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, required $finish earlier");
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    DrawX = '0;
    DrawY = '0;
    new_frame = 1'b0;
    lb.lb_sdram_Wait = 1'b0;
`ifdef LB_FRAME_SWAP_EN
    fb_select = 1'b0;
`endif
    tick(2);
    check("reset_rd",       32'(lb.lb_sdram_rd), 0);
    check("reset_busy",     32'(lb.lb_Busy), 0);
    check("reset_done",     32'(lb.lb_done), 0);
    check("reset_pixel",    32'(pixel_out), 0);
    check("reset_underrun", 32'(lb_underrun), 0);
    check("reset_addr",     32'(lb.lb_sdram_addr), 0);
    reset = 1'b0;
    tick();

    // line 11: addresses 880..959
    push_line(11, 0, 80);
    trigger(10'd10);
    check("busy_start_11", 32'(lb.lb_Busy), 1);
    wait_idle("fetch_11_end", 400);
    check("reads_11_all", 32'(addr_q.size()), 0);
    check("done_11", 32'(lb.lb_done), 0);
    check("underrun_11", 32'(lb_underrun), 0);

    // line 479: addresses 38320..38399, sets done
    push_line(479, 0, 80);
    trigger(10'd478);
    wait_idle("fetch_479_end", 400);
    check("reads_479_all", 32'(addr_q.size()), 0);
    check("done_479", 32'(lb.lb_done), 1);
    tick(5);
    check("done_hold", 32'(lb.lb_done), 1);
    new_frame = 1'b1;
    tick();
    new_frame = 1'b0;
    check("done_clear", 32'(lb.lb_done), 0);

    // displayed bank holds line 11
    DrawY = 10'd11;
    for (int x = 24; x < 32; x++) push_pix("pixel_w3", 10'(x), 16'(x - 24));
    push_pix("pixel_x700", 10'd700, 16'h0000);
    push_pix("pixel_x0", 10'd0, 16'h0300);
    DrawY = 10'd480;
    push_pix("pixel_y480", 10'd24, 16'h0000);
    DrawY = 10'd11;
    tick(2);

    // grant revoked at idx 5 of line 21
    push_line(21, 0, 80);
    trigger(10'd20);
    wait_req("reach_idx5", 22'd1685, 100);
    lb.lb_sdram_Wait = 1'b1;
    tick();
    check("revoke_rd_low", 32'(lb.lb_sdram_rd), 0);
    tick(3);
    check("revoke_rd_hold", 32'(lb.lb_sdram_rd), 0);
    lb.lb_sdram_Wait = 1'b0;
    tick();
    check("regrant_rd", 32'(lb.lb_sdram_rd), 1);
    check("regrant_addr", 32'(lb.lb_sdram_addr), 1685);
    wait_idle("fetch_21_end", 400);
    check("reads_21_all", 32'(addr_q.size()), 0);

    // underrun: line 31 stalls at word 2, next trigger restarts at line 32 word 0
    push_line(31, 0, 3);
    trigger(10'd30);
    wait_req("reach_idx2", 22'd2482, 100);
    ac_en = 1'b0;
    tick(4);
    check("stall_rd", 32'(lb.lb_sdram_rd), 1);
    check("stall_busy", 32'(lb.lb_Busy), 1);
    push_line(32, 0, 80);
    trigger(10'd31);
    check("underrun_set", 32'(lb_underrun), 1);
    ac_en = 1'b1;
    wait_idle("fetch_32_end", 400);
    check("reads_32_all", 32'(addr_q.size()), 0);
    check("underrun_sticky", 32'(lb_underrun), 1);
    DrawY = 10'd5;
    push_pix("swap_w0", 10'd0, 16'h1700);
    push_pix("swap_w1", 10'd8, 16'h1600);
    tick(2);

    // done again, then wrap to line 0 stalled in REQ and async reset
    push_line(479, 0, 80);
    trigger(10'd478);
    wait_idle("fetch_479b_end", 400);
    check("done_again", 32'(lb.lb_done), 1);
    ac_en = 1'b0;
    trigger(10'd524);
    check("wrap_busy", 32'(lb.lb_Busy), 1);
    DrawY = 10'd5;
    DrawX = 10'd0;
    tick(3);
    check("wrap_rd", 32'(lb.lb_sdram_rd), 1);
    check("wrap_addr", 32'(lb.lb_sdram_addr), 0);
    check("pre_reset_done", 32'(lb.lb_done), 1);
    check("pre_reset_pixel", 32'(pixel_out), 32'h0000D700);
    #2;
    reset = 1'b1;
    #1;
    check("async_rd", 32'(lb.lb_sdram_rd), 0);
    check("async_busy", 32'(lb.lb_Busy), 0);
    check("async_done", 32'(lb.lb_done), 0);
    check("async_pixel", 32'(pixel_out), 0);
    check("async_underrun", 32'(lb_underrun), 0);
    tick();
    reset = 1'b0;
    ac_en = 1'b1;
    tick(2);
    check("post_reset_rd", 32'(lb.lb_sdram_rd), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
